sc_fifo_regs: RTL

Single-clock, parametrised FIFO with a register interface. It is the next-generation single-clock counterpart of the team's dual-clock FIFO wrapper. Added features:
- programmable almost-full and almost-empty thresholds
- fill-level readback
- sticky overflow and underflow flags
- a data-valid output
- selectable first-word-fall-through (FWFT) or standard read mode

It sits between a producer/consumer datapath and the simple memory-mapped register bus.

---
 rtl/sc_fifo_regs.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sc_fifo_regs.sv
// Single-clock FIFO with register bus: thresholds, level readback, sticky ovf/udf,
// and selectable first-word-fall-through or standard (registered) read mode.
module sc_fifo_regs #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int REG_DW = 8,
  parameter int REG_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_req,
  input  logic              reg_wr,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [REG_DW-1:0] reg_wdata,
  output logic [REG_DW-1:0] reg_rdata,
  input  logic [DW-1:0]     din,
  input  logic              we,
  input  logic              re,
  output logic [DW-1:0]     dout,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] AFULL_RST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] AEMPTY_RST = (AW+1)'(1);

  localparam logic [REG_AW-1:0] A_RESET  = REG_AW'(0);
  localparam logic [REG_AW-1:0] A_CFG    = REG_AW'(1);
  localparam logic [REG_AW-1:0] A_STATUS = REG_AW'(2);
  localparam logic [REG_AW-1:0] A_LEVEL  = REG_AW'(3);
  localparam logic [REG_AW-1:0] A_AFTH   = REG_AW'(4);
  localparam logic [REG_AW-1:0] A_AETH   = REG_AW'(5);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr, r_count;
  logic [AW:0]   r_afull_th, r_aempty_th;
  logic          r_full, r_empty, r_afull, r_aempty;
  logic          r_ovf, r_udf, r_fwft;
  logic [DW-1:0] r_dout;
  logic          r_rvalid;
  logic [REG_DW-1:0] r_rdata;

  logic          w_reg_wr, w_soft_clr;
  logic          w_wr_acc, w_rd_acc, w_ovf_evt, w_udf_evt;
  logic          w_std_rd;
  logic [AW:0]   w_th_sat, w_cnt_nxt, w_afth_nxt, w_aeth_nxt;
  logic [DW-1:0] w_mem_rd;
  logic [REG_DW-1:0] w_rd_mux;

  // Handshake: a write is taken on any edge where we=1 and full=0; a read is
  // taken on any edge where re=1 and empty=0. A soft clear masks both.
  assign w_reg_wr   = reg_req & reg_wr;
  assign w_soft_clr = w_reg_wr && (reg_addr == A_RESET) && reg_wdata[0];
  assign w_wr_acc   = we & ~r_full & ~w_soft_clr;
  assign w_rd_acc   = re & ~r_empty & ~w_soft_clr;
  assign w_ovf_evt  = we & r_full & ~w_soft_clr;
  assign w_udf_evt  = re & r_empty & ~w_soft_clr;
  assign w_std_rd   = w_rd_acc & ~r_fwft;
  assign w_mem_rd   = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_th_sat = reg_wdata[AW:0];
    if (reg_wdata > REG_DW'(DEPTH)) w_th_sat = DEPTH_C;
  end

  always_comb begin
    w_cnt_nxt  = r_count;
    w_afth_nxt = r_afull_th;
    w_aeth_nxt = r_aempty_th;
    if (w_soft_clr) begin
      w_cnt_nxt  = '0;
      w_afth_nxt = AFULL_RST;
      w_aeth_nxt = AEMPTY_RST;
    end else begin
      if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + PTR_ONE;
      else if (!w_wr_acc && w_rd_acc) w_cnt_nxt = r_count - PTR_ONE;
      if (w_reg_wr && reg_addr == A_AFTH) w_afth_nxt = w_th_sat;
      if (w_reg_wr && reg_addr == A_AETH) w_aeth_nxt = w_th_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= din;
  end

  // Flags are computed from next-state count and thresholds so they track both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_afull_th  <= AFULL_RST;
      r_aempty_th <= AEMPTY_RST;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_fwft      <= 1'b0;
      r_dout      <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_count     <= w_cnt_nxt;
      r_afull_th  <= w_afth_nxt;
      r_aempty_th <= w_aeth_nxt;
      r_full      <= (w_cnt_nxt == DEPTH_C);
      r_empty     <= (w_cnt_nxt == '0);
      r_afull     <= (w_cnt_nxt >= w_afth_nxt);
      r_aempty    <= (w_cnt_nxt <= w_aeth_nxt);
      if (w_soft_clr) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
        r_fwft   <= 1'b0;
        r_rvalid <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
        if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
        if (w_ovf_evt)                                            r_ovf <= 1'b1;
        else if (w_reg_wr && reg_addr == A_STATUS && reg_wdata[4]) r_ovf <= 1'b0;
        if (w_udf_evt)                                            r_udf <= 1'b1;
        else if (w_reg_wr && reg_addr == A_STATUS && reg_wdata[5]) r_udf <= 1'b0;
        if (w_reg_wr && reg_addr == A_CFG) r_fwft <= reg_wdata[0];
        r_rvalid <= w_std_rd;
        if (w_std_rd) r_dout <= w_mem_rd;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      A_CFG:    w_rd_mux = REG_DW'(r_fwft);
      A_STATUS: w_rd_mux = REG_DW'({r_udf, r_ovf, r_aempty, r_afull, r_empty, r_full});
      A_LEVEL:  w_rd_mux = REG_DW'(r_count);
      A_AFTH:   w_rd_mux = REG_DW'(r_afull_th);
      A_AETH:   w_rd_mux = REG_DW'(r_aempty_th);
      default:  w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_rdata <= '0;
    else if (reg_req && !reg_wr) r_rdata <= w_rd_mux;
  end

  // A standard-mode pulse still in flight after a switch to FWFT shows the registered word.
  assign dout         = (r_fwft && !r_rvalid) ? w_mem_rd : r_dout;
  assign rvalid       = r_fwft ? (~r_empty | r_rvalid) : r_rvalid;
  assign reg_rdata    = r_rdata;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule
